// File: rtl/interval_mode_tracker_pkg.sv
// Shared types and constants for the interval mode tracker.
// This file holds the one-hot mode type, the lane-index width helper and the escalation event record.
package interval_mode_tracker_pkg;

    localparam int NUM_MODES = 8;
    localparam int DEF_LANES = 12;

    typedef logic [NUM_MODES-1:0] mode_t;

    localparam mode_t MODE_INIT = mode_t'(1);
    localparam mode_t MODE_TOP  = {1'b1, {(NUM_MODES-1){1'b0}}};

    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int DEF_LANE_W = lane_w(DEF_LANES);

    typedef struct packed {
        logic [DEF_LANE_W-1:0] lane;
        mode_t                 mode;
    } evt_t;

endpackage

// File: rtl/interval_mode_tracker_if.sv
// Bundle between the interval-check stage and the tracker.
// It carries the flag beat handshake, per-lane mode and count feedback, and the escalation event handshake.
interface interval_mode_tracker_if
    import interval_mode_tracker_pkg::*;
#(
    parameter int PARALLEL_SIZE = DEF_LANES,
    parameter int CNT_W         = 16
);
    localparam int LANE_W = lane_w(PARALLEL_SIZE);

    logic                                valid;
    logic                                ready;
    logic [PARALLEL_SIZE-1:0]            out_of_mode_interval;
    mode_t [PARALLEL_SIZE-1:0]           mode;
    logic [PARALLEL_SIZE-1:0][CNT_W-1:0] interval_cnt;
    logic [PARALLEL_SIZE-1:0]            sat;
    logic                                evt_valid;
    logic                                evt_ready;
    logic [LANE_W-1:0]                   evt_lane;
    mode_t                               evt_mode;

    modport master (
        output valid, out_of_mode_interval, evt_ready,
        input  ready, mode, interval_cnt, sat, evt_valid, evt_lane, evt_mode
    );

    modport slave (
        input  valid, out_of_mode_interval, evt_ready,
        output ready, mode, interval_cnt, sat, evt_valid, evt_lane, evt_mode
    );

endinterface

// File: rtl/interval_mode_tracker_lane_ctr.sv
// Tracks one lane: its violation counter, its one-hot mode and its sticky saturation flag.
// The escalate output pulses during the beat that moves the lane to its next mode.
module interval_lane_ctr
    import interval_mode_tracker_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int ESC_THRESH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             beat_i,
    input  logic             flag_i,
    input  logic             wrap_i,
    output mode_t            mode_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o,
    output logic             escalate_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ESC_THRESH - 1);

    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             esc;

    // At the top mode the counter parks on LAST_CNT, so every further flag re-hits the threshold harmlessly
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        esc    = 1'b0;
        if (beat_i && flag_i) begin
            if (cnt_q != LAST_CNT) begin
                cnt_d = cnt_q + 1'b1;
            end else if (mode_q != MODE_TOP) begin
                mode_d = mode_q << 1;
                cnt_d  = '0;
                esc    = 1'b1;
            end else begin
                sat_d = 1'b1;
            end
        end
        if (beat_i && wrap_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_INIT;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign mode_o     = mode_q;
    assign cnt_o      = cnt_q;
    assign sat_o      = sat_q;
    assign escalate_o = esc;

endmodule

// File: rtl/interval_mode_tracker.sv
// Per-lane escalation tracker that sits behind the interval-check stage.
// Lane counters live in interval_lane_ctr; this level owns the window counter, the pending mask and event reporting.
module interval_mode_tracker
    import interval_mode_tracker_pkg::*;
#(
    parameter int PARALLEL_SIZE = DEF_LANES,
    parameter int CNT_W         = 16,
    parameter int ESC_THRESH    = 64,
    parameter int WINDOW        = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    interval_mode_tracker_if.slave trk_if
);

    localparam int LANE_W = lane_w(PARALLEL_SIZE);
    localparam int BEAT_W = $clog2(WINDOW);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WINDOW - 1);

    typedef enum logic {IDLE, REPORT} state_t;

    state_t                              state_q;
    logic [BEAT_W-1:0]                   beatCnt_q;
    logic [PARALLEL_SIZE-1:0]            pending_q, pending_d;
    logic                                ready_q;
    logic                                evtValid_q;
    logic [LANE_W-1:0]                   evtLane_q;
    logic [LANE_W-1:0]                   pick;
    logic                                laneRst, accept, wrap, taken;
    mode_t [PARALLEL_SIZE-1:0]           modeW;
    logic [PARALLEL_SIZE-1:0][CNT_W-1:0] cntW;
    logic [PARALLEL_SIZE-1:0]            satW;
    logic [PARALLEL_SIZE-1:0]            escW;
    evt_t                                evtPay;

    assign laneRst = rst_i | clear_i;
    assign accept  = trk_if.valid & ready_q;
    assign wrap    = accept & (beatCnt_q == LAST_BEAT);
    assign taken   = evtValid_q & trk_if.evt_ready;

    for (genvar g = 0; g < PARALLEL_SIZE; g++) begin : g_lane
        interval_lane_ctr #(
            .CNT_W      (CNT_W),
            .ESC_THRESH (ESC_THRESH)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_i      (laneRst),
            .beat_i     (accept),
            .flag_i     (trk_if.out_of_mode_interval[g]),
            .wrap_i     (wrap),
            .mode_o     (modeW[g]),
            .cnt_o      (cntW[g]),
            .sat_o      (satW[g]),
            .escalate_o (escW[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (laneRst) begin
            beatCnt_q <= '0;
        end else if (accept) begin
            beatCnt_q <= wrap ? '0 : beatCnt_q + 1'b1;
        end
    end

    // Beats and event hand-offs never coincide because ready is low for the whole REPORT phase
    always_comb begin
        pending_d = pending_q;
        if (taken) begin
            pending_d[evtLane_q] = 1'b0;
        end
        if (accept) begin
            pending_d = pending_d | escW;
        end
        pick = '0;
        for (int i = PARALLEL_SIZE - 1; i >= 0; i--) begin
            if (pending_d[i]) begin
                pick = LANE_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (laneRst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            ready_q    <= 1'b1;
            evtValid_q <= 1'b0;
            evtLane_q  <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (pending_q != '0) begin
                        state_q    <= REPORT;
                        ready_q    <= 1'b0;
                        evtValid_q <= 1'b1;
                        evtLane_q  <= pick;
                    end
                end
                REPORT: begin
                    if (taken) begin
                        if (pending_d == '0) begin
                            state_q    <= IDLE;
                            ready_q    <= 1'b1;
                            evtValid_q <= 1'b0;
                        end else begin
                            evtLane_q <= pick;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The reported mode is read live; lane modes cannot move while an event is outstanding
    assign evtPay = '{lane: DEF_LANE_W'(evtLane_q), mode: modeW[evtLane_q]};

    assign trk_if.ready        = ready_q;
    assign trk_if.mode         = modeW;
    assign trk_if.interval_cnt = cntW;
    assign trk_if.sat          = satW;
    assign trk_if.evt_valid    = evtValid_q;
    assign trk_if.evt_lane     = LANE_W'(evtPay.lane);
    assign trk_if.evt_mode     = evtPay.mode;

endmodule

// File: tb/tb_interval_mode_tracker.sv
// Bench for interval_mode_tracker: directed vector table for the documented scenarios,
// then random traffic compared every cycle against a lane-level reference model.
module tb_interval_mode_tracker;

    localparam int N   = 12;
    localparam int CW  = 16;
    localparam int TH  = 64;
    localparam int WIN = 1024;

    typedef struct {
        string        name;
        int           reps;
        bit           rst;
        bit           clr;
        bit           valid;
        logic [N-1:0] flags;
        bit           er;
        int           lane;
        logic [7:0]   expMode;
        int           expCnt;
        bit           expSat;
        bit           expReady;
        bit           expEvtValid;
        int           expEvtLane;
        logic [7:0]   expEvtMode;
    } vec_t;

    logic clk;
    logic rst;
    logic clear;
    int   nChecks = 0;
    int   nFails  = 0;
    vec_t vecs[$];

    // Reference model state, kept as plain per-lane integers
    int mCnt[N];
    int mModeIdx[N];
    bit mSat[N];
    bit mPend[N];
    int mBeats;
    bit mReporting;

    interval_mode_tracker_if #(.PARALLEL_SIZE(N), .CNT_W(CW)) bus ();

    interval_mode_tracker #(
        .PARALLEL_SIZE (N),
        .CNT_W         (CW),
        .ESC_THRESH    (TH),
        .WINDOW        (WIN)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .trk_if  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mLowest();
        for (int i = 0; i < N; i++) begin
            if (mPend[i]) return i;
        end
        return 0;
    endfunction

    function automatic bit mAny();
        for (int i = 0; i < N; i++) begin
            if (mPend[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            mCnt[i]     = 0;
            mModeIdx[i] = 0;
            mSat[i]     = 1'b0;
            mPend[i]    = 1'b0;
        end
        mBeats     = 0;
        mReporting = 1'b0;
    endfunction

    function automatic void modelStep(input bit r, input bit c, input bit v, input logic [N-1:0] f, input bit er);
        bit wasPend;
        bit taken;
        if (r || c) begin
            modelReset();
            return;
        end
        wasPend = mAny();
        taken   = mReporting && er;
        if (taken) mPend[mLowest()] = 1'b0;
        if (v && !mReporting) begin
            for (int i = 0; i < N; i++) begin
                if (f[i]) begin
                    if (mCnt[i] + 1 < TH) begin
                        mCnt[i]++;
                    end else if (mModeIdx[i] < 7) begin
                        mModeIdx[i]++;
                        mCnt[i]  = 0;
                        mPend[i] = 1'b1;
                    end else begin
                        mSat[i] = 1'b1;
                        mCnt[i] = TH - 1;
                    end
                end
            end
            if (mBeats == WIN - 1) begin
                for (int i = 0; i < N; i++) mCnt[i] = 0;
            end
            mBeats = (mBeats + 1) % WIN;
        end
        if (!mReporting) mReporting = wasPend;
        else if (taken && !mAny()) mReporting = 1'b0;
    endfunction

    function automatic void add(input string name, input int reps, input bit r, input bit c, input bit v,
                                input logic [N-1:0] f, input bit er, input int lane, input logic [7:0] expMode,
                                input int expCnt, input bit expSat, input bit expReady, input bit expEvtValid,
                                input int expEvtLane, input logic [7:0] expEvtMode);
        vec_t t;
        t.name = name; t.reps = reps; t.rst = r; t.clr = c; t.valid = v; t.flags = f; t.er = er;
        t.lane = lane; t.expMode = expMode; t.expCnt = expCnt; t.expSat = expSat; t.expReady = expReady;
        t.expEvtValid = expEvtValid; t.expEvtLane = expEvtLane; t.expEvtMode = expEvtMode;
        vecs.push_back(t);
    endfunction

    task automatic applyStimulus(input bit r, input bit c, input bit v, input logic [N-1:0] f, input bit er);
        rst                      = r;
        clear                    = c;
        bus.valid                = v;
        bus.out_of_mode_interval = f;
        bus.evt_ready            = er;
        @(posedge clk);
        modelStep(r, c, v, f, er);
        #1;
    endtask

    task automatic checkField(input string name, input string field, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t t);
        checkField(t.name, "mode", 64'(bus.mode[t.lane]), 64'(t.expMode));
        checkField(t.name, "cnt", 64'(bus.interval_cnt[t.lane]), 64'(t.expCnt));
        checkField(t.name, "sat", 64'(bus.sat[t.lane]), 64'(t.expSat));
        checkField(t.name, "ready", 64'(bus.ready), 64'(t.expReady));
        checkField(t.name, "evt_valid", 64'(bus.evt_valid), 64'(t.expEvtValid));
        if (t.expEvtValid) begin
            checkField(t.name, "evt_lane", 64'(bus.evt_lane), 64'(t.expEvtLane));
            checkField(t.name, "evt_mode", 64'(bus.evt_mode), 64'(t.expEvtMode));
        end
    endtask

    task automatic checkModel(input int cyc);
        string tag;
        tag = $sformatf("rand@%0d", cyc);
        for (int i = 0; i < N; i++) begin
            checkField(tag, $sformatf("mode[%0d]", i), 64'(bus.mode[i]), 64'(1) << mModeIdx[i]);
            checkField(tag, $sformatf("cnt[%0d]", i), 64'(bus.interval_cnt[i]), 64'(mCnt[i]));
            checkField(tag, $sformatf("sat[%0d]", i), 64'(bus.sat[i]), 64'(mSat[i]));
        end
        checkField(tag, "ready", 64'(bus.ready), 64'(!mReporting));
        checkField(tag, "evt_valid", 64'(bus.evt_valid), 64'(mReporting));
        if (mReporting) begin
            checkField(tag, "evt_lane", 64'(bus.evt_lane), 64'(mLowest()));
            checkField(tag, "evt_mode", 64'(bus.evt_mode), 64'(1) << mModeIdx[mLowest()]);
        end
    endtask

    initial begin
        modelReset();
        rst = 1'b1; clear = 1'b0;
        bus.valid = 1'b0; bus.out_of_mode_interval = '0; bus.evt_ready = 1'b1;

        add("reset",        1, 1, 0, 0, 12'h000, 1, 0, 8'h01, 0, 0, 1, 0, 0, 8'h00);
        add("idle",         5, 0, 0, 0, 12'h000, 1, 3, 8'h01, 0, 0, 1, 0, 0, 8'h00);
        add("lane3_pre",   63, 0, 0, 1, 12'h008, 1, 3, 8'h01, 63, 0, 1, 0, 0, 8'h00);
        add("lane3_esc",    1, 0, 0, 1, 12'h008, 1, 3, 8'h02, 0, 0, 1, 0, 0, 8'h00);
        add("lane3_evt",    1, 0, 0, 0, 12'h000, 1, 3, 8'h02, 0, 0, 0, 1, 3, 8'h02);
        add("lane3_idle",   1, 0, 0, 0, 12'h000, 1, 3, 8'h02, 0, 0, 1, 0, 0, 8'h00);
        add("multi_pre",   63, 0, 0, 1, 12'h222, 1, 5, 8'h01, 63, 0, 1, 0, 0, 8'h00);
        add("multi_esc",    1, 0, 0, 1, 12'h222, 0, 5, 8'h02, 0, 0, 1, 0, 0, 8'h00);
        add("evt1_first",   1, 0, 0, 0, 12'h000, 0, 1, 8'h02, 0, 0, 0, 1, 1, 8'h02);
        add("evt1_stall_a", 1, 0, 0, 1, 12'h222, 0, 5, 8'h02, 0, 0, 0, 1, 1, 8'h02);
        add("evt1_stall_b", 1, 0, 0, 0, 12'h000, 0, 1, 8'h02, 0, 0, 0, 1, 1, 8'h02);
        add("evt5",         1, 0, 0, 0, 12'h000, 1, 5, 8'h02, 0, 0, 0, 1, 5, 8'h02);
        add("evt9",         1, 0, 0, 0, 12'h000, 1, 9, 8'h02, 0, 0, 0, 1, 9, 8'h02);
        add("evt_done",     1, 0, 0, 0, 12'h000, 1, 9, 8'h02, 0, 0, 1, 0, 0, 8'h00);
        add("sat_rst",      1, 1, 0, 0, 12'h000, 1, 0, 8'h01, 0, 0, 1, 0, 0, 8'h00);
        for (int k = 1; k < 8; k++) begin
            add("sat_climb",  64, 0, 0, 1, 12'h001, 1, 0, 8'(1 << k), 0, 0, 1, 0, 0, 8'h00);
            add("sat_report",  2, 0, 0, 0, 12'h000, 1, 0, 8'(1 << k), 0, 0, 1, 0, 0, 8'h00);
        end
        add("sat_pre",     63, 0, 0, 1, 12'h001, 1, 0, 8'h80, 63, 0, 1, 0, 0, 8'h00);
        add("sat_hit",      1, 0, 0, 1, 12'h001, 1, 0, 8'h80, 63, 1, 1, 0, 0, 8'h00);
        add("sat_noevt",    2, 0, 0, 0, 12'h000, 1, 0, 8'h80, 63, 1, 1, 0, 0, 8'h00);
        add("sat_more",     5, 0, 0, 1, 12'h001, 1, 0, 8'h80, 63, 1, 1, 0, 0, 8'h00);
        add("win_rst",      1, 1, 0, 0, 12'h000, 1, 2, 8'h01, 0, 0, 1, 0, 0, 8'h00);
        add("win_flags",   10, 0, 0, 1, 12'h004, 1, 2, 8'h01, 10, 0, 1, 0, 0, 8'h00);
        add("win_fill",  1013, 0, 0, 1, 12'h000, 1, 2, 8'h01, 10, 0, 1, 0, 0, 8'h00);
        add("win_wrap",     1, 0, 0, 1, 12'h000, 1, 2, 8'h01, 0, 0, 1, 0, 0, 8'h00);
        add("win_pre",    960, 0, 0, 1, 12'h000, 1, 4, 8'h01, 0, 0, 1, 0, 0, 8'h00);
        add("win_esc_pre", 63, 0, 0, 1, 12'h010, 1, 4, 8'h01, 63, 0, 1, 0, 0, 8'h00);
        add("win_esc_wrap", 1, 0, 0, 1, 12'h010, 1, 4, 8'h02, 0, 0, 1, 0, 0, 8'h00);
        add("win_esc_evt",  1, 0, 0, 0, 12'h000, 1, 4, 8'h02, 0, 0, 0, 1, 4, 8'h02);
        add("win_esc_idle", 1, 0, 0, 0, 12'h000, 1, 4, 8'h02, 0, 0, 1, 0, 0, 8'h00);
        add("clr_flags",   64, 0, 0, 1, 12'h040, 1, 6, 8'h02, 0, 0, 1, 0, 0, 8'h00);
        add("clr_report",   1, 0, 0, 0, 12'h000, 0, 6, 8'h02, 0, 0, 0, 1, 6, 8'h02);
        add("clr_hit",      1, 0, 1, 0, 12'h000, 0, 6, 8'h01, 0, 0, 1, 0, 0, 8'h00);
        add("clr_after",    2, 0, 0, 0, 12'h000, 0, 4, 8'h01, 0, 0, 1, 0, 0, 8'h00);

        foreach (vecs[v]) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                applyStimulus(vecs[v].rst, vecs[v].clr, vecs[v].valid, vecs[v].flags, vecs[v].er);
            end
            checkOutput(vecs[v]);
        end

        // Random traffic: dense flags so lanes escalate, saturate and cross window boundaries
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checkModel(0);
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            applyStimulus(1'b0, $urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                          N'($urandom), $urandom_range(0, 3) != 0);
            checkModel(cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/interval_mode_tracker.md
Name: interval_mode_tracker

Overview:
- Feedback partner of the interval-check stage. That stage compares the shifted score (s + (-max_score)) against one mode's interval and produces per-lane out_of_mode_interval flags.
- This block consumes those flags and keeps per-lane violation counters. It escalates each lane's one-hot mode (8'h01 -> 8'h80) when a lane's violation count reaches a threshold.
- It drives mode and interval_cnt back into the check stage and reports each escalation as a handshaked event.

Parameters:
- PARALLEL_SIZE, 12, number of lanes.
- CNT_W, 16, per-lane violation counter width (matches para).
- NUM_MODES, 8, one-hot mode width.
- ESC_THRESH, 64, violations within a window that trigger escalation (1..2^CNT_W-1).
- WINDOW, 1024, accepted beats per observation window (>=2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous soft clear of all lane state (same effect as reset).
- valid_i  in  1  flag beat valid.
- ready_o  out  1  block can accept a beat.
- out_of_mode_interval_i  in  PARALLEL_SIZE  per-lane violation flags.
- mode_o  out  PARALLEL_SIZE x NUM_MODES  per-lane one-hot mode to the check stage.
- interval_cnt_o  out  PARALLEL_SIZE x CNT_W  per-lane violation count in the current window.
- sat_o  out  PARALLEL_SIZE  sticky: lane hit the threshold while at top mode.
- evt_valid_o  out  1  escalation event valid.
- evt_ready_i  in  1  event consumer ready.
- evt_lane_o  out  $clog2(PARALLEL_SIZE)  lane index of the event.
- evt_mode_o  out  NUM_MODES  new mode of that lane.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.

Reset and clear:
- On rst_i or clear_i, the following reset values are registered: mode_o = 8'h01 for all lanes; interval_cnt_o = 0; sat_o = 0; beat counter = 0; pending mask = 0; evt_valid_o = 0; ready_o = 1.
- rst_i/clear_i override any beat or event handshake in the same cycle. An in-flight event is dropped.

Beat acceptance:
- A beat is accepted when valid_i & ready_o.
- All registered outputs reflect the beat on the next cycle (latency 1).

Per-lane update on an accepted beat:
- Flag = 0: the counter holds.
- Flag = 1 and cnt+1 < ESC_THRESH: cnt <= cnt+1.
- Flag = 1 and cnt+1 == ESC_THRESH, mode != 8'h80: mode <= mode << 1; cnt <= 0; set the lane's pending bit.
- Flag = 1 and cnt+1 == ESC_THRESH, mode == 8'h80: mode holds; sat_o[lane] <= 1; cnt saturates at ESC_THRESH-1; no event.

Window handling:
- The beat counter counts accepted beats from 0 to WINDOW-1 and wraps.
- On the beat that wraps it, all lane counters clear to 0 after this beat's per-lane update; mode is not changed.
- If escalation and wrap happen on the same beat, the escalation still happens and the counter ends at 0.

Event FSM (IDLE / REPORT):
- IDLE: evt_valid_o = 0, ready_o = 1. Moves to REPORT when the pending mask is non-zero after a beat.
- REPORT: evt_valid_o = 1; evt_lane_o = lowest set pending bit; evt_mode_o = that lane's current mode_o.
  - On evt_ready_i, clear that bit. Return to IDLE when the mask becomes empty.
  - ready_o = 0 throughout REPORT, so no beats are accepted while events are outstanding.
- evt_lane_o/evt_mode_o are stable while evt_valid_o & !evt_ready_i.
- One event is issued per cycle at most, lowest lane index first.

Arithmetic:
- Counters are unsigned CNT_W bits and never wrap.
- Mode stays one-hot at all times. An illegal mode value cannot arise.

Decomposition:
- A shared package holds:
  - mode_t (logic [NUM_MODES-1:0]);
  - MODE_INIT = 8'h01 and MODE_TOP = 8'h80;
  - the lane-index width function;
  - evt_t struct {lane, mode}.
- One sub-module, interval_lane_ctr, holds a single lane's counter, mode and sat logic, with inputs beat, flag and wrap, and outputs mode, cnt, sat and escalate. It is instantiated PARALLEL_SIZE times.
- The top level holds the beat counter, the pending mask, the priority pick and the event FSM.

Test Plan:
- Reset, then idle 5 cycles -> all mode_o = 8'h01, interval_cnt_o = 0, sat_o = 0, ready_o = 1, evt_valid_o = 0.
- Lane 3 flag = 1 for 64 consecutive beats (ESC_THRESH = 64), evt_ready_i = 1 -> after beat 64, mode_o[3] = 8'h02 and cnt[3] = 0. Next cycle: evt_valid_o = 1, evt_lane_o = 3, evt_mode_o = 8'h02, ready_o = 0. Then IDLE.
- Lanes 1, 5 and 9 reach the threshold on the same beat, with evt_ready_i held 0 for 3 cycles and then 1 -> events issue in order lane 1, 5, 9. Payload is stable during the stall. ready_o = 0 until lane 9's event is taken.
- Lane 0 escalated 7 times to 8'h80, then 64 more flags -> sat_o[0] = 1, mode stays 8'h80, cnt = 63, no event.
- WINDOW = 1024 with lane 2 flagged on 10 beats -> after the 1024th beat, cnt[2] = 0 and mode unchanged. Also, escalation on the 1024th beat -> mode shifts and cnt = 0.
- clear_i asserted while in REPORT with evt_ready_i = 0 -> next cycle: all state at reset values, evt_valid_o = 0, ready_o = 1.
